// File: rtl/sw_port_pkg.sv
// sw_port_pkg: shared switch-port constants and the per-bit debounce state.
//   SW_WIDTH          switch count (bit 8 = mode, bits 7:0 = data byte)
//   DB_CYCLES_DEFAULT default number of stable cycles needed to accept a change
//   db_state_t        STABLE (synchronized level matches output) / COUNTING
package sw_port_pkg;

    localparam int SW_WIDTH          = 9;
    localparam int DB_CYCLES_DEFAULT = 16;

    typedef enum logic {STABLE, COUNTING} db_state_t;

    // Counter width is max(1, clog2(cycles)); terminal count cycles-1 always fits.
    function automatic int cnt_width(input int cycles);
        return ($clog2(cycles) > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sw_input_port_if.sv
// sw_input_port_if: switch-port signal bundle.
//   sw_pin     raw asynchronous switch levels (into the port)
//   sw         conditioned switch value (out of the port)
//   sw_changed one-cycle pulse when any bit of sw changes
//   sw_event   sticky change flag
//   sw_ack     clears sw_event
// Modports: master = the environment driving the pins, slave = sw_input_port.
interface sw_input_port_if import sw_port_pkg::*; #(
    parameter int n = SW_WIDTH
);

    logic [n-1:0] sw_pin;
    logic [n-1:0] sw;
    logic         sw_changed;
    logic         sw_event;
    logic         sw_ack;

    modport master (output sw_pin, sw_ack, input sw, sw_changed, sw_event);
    modport slave  (input sw_pin, sw_ack, output sw, sw_changed, sw_event);

endinterface

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one switch bit -- two-flop synchronizer plus optional debounce counter.
//   clk, reset  clock and synchronous active-high reset
//   i_pin       raw asynchronous pin level
//   o_sw        conditioned output bit
//   o_upd       high in the cycle before o_sw toggles (o_sw takes the new value at the next edge)
// Build option: define SW_DEBOUNCE_EN to enable the debounce counter; otherwise o_sw is the
// second synchronizer flop.
module sw_debounce_bit import sw_port_pkg::*; #(
    parameter int db_cycles = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_sw,
    output logic o_upd
);

    if (db_cycles < 2 || db_cycles > 65535) begin : g_bad_db
        $error("sw_debounce_bit: db_cycles must be within 2..65535");
    end

    logic r_sync1;
    logic r_sync2;

`ifdef SW_DEBOUNCE_EN

    localparam int            CW   = cnt_width(db_cycles);
    localparam logic [CW-1:0] TERM = CW'(db_cycles - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sw;
    db_state_t     w_state;

    always_comb w_state = (r_sync2 == r_sw) ? STABLE : COUNTING;

    // The change is accepted on the db_cycles-th consecutive mismatch edge.
    assign o_upd = (w_state == COUNTING) && (r_cnt == TERM);
    assign o_sw  = r_sw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sw    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (w_state == STABLE) begin
                r_cnt <= '0;
            end else if (o_upd) begin
                r_sw  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`else

    // Without debounce the output is the second synchronizer flop itself,
    // so it changes whenever the two flops disagree.
    assign o_sw  = r_sync2;
    assign o_upd = r_sync1 ^ r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

`endif

endmodule

// File: rtl/sw_input_port.sv
// sw_input_port: conditions n raw switch pins into a clean sw value with change pulse and sticky event.
//   clk, reset  clock and synchronous active-high reset
//   bus         sw_input_port_if.slave: sw_pin in, sw out, sw_changed/sw_event out, sw_ack in
// Build option: SW_DEBOUNCE_EN enables per-bit debouncing (latency 2+db_cycles edges);
// without it sw is the synchronized pin value (latency 2 edges).
module sw_input_port import sw_port_pkg::*; #(
    parameter int n         = SW_WIDTH,
    parameter int db_cycles = DB_CYCLES_DEFAULT
) (
    input logic            clk,
    input logic            reset,
    sw_input_port_if.slave bus
);

    logic [n-1:0] w_sw;
    logic [n-1:0] w_upd;
    logic         r_changed;
    logic         r_event;

    for (genvar i = 0; i < n; i++) begin : g_bit
        sw_debounce_bit #(
            .db_cycles(db_cycles)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .i_pin (bus.sw_pin[i]),
            .o_sw  (w_sw[i]),
            .o_upd (w_upd[i])
        );
    end

    assign bus.sw         = w_sw;
    assign bus.sw_changed = r_changed;
    assign bus.sw_event   = r_event;

    // Both flags are registered from the update strobes, so they appear in the
    // same cycle sw shows the new value; simultaneous bit updates give one pulse.
    // A coinciding ack loses to a new update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_changed <= 1'b0;
            r_event   <= 1'b0;
        end else begin
            r_changed <= |w_upd;
            r_event   <= (|w_upd) | (r_event & ~bus.sw_ack);
        end
    end

endmodule

// File: tb/tb_sw_input_port.sv
// tb_sw_input_port: self-checking bench for sw_input_port (n=9, db_cycles=4), either build.
module tb_sw_input_port;
    import sw_port_pkg::*;

    localparam int N  = SW_WIDTH;
    localparam int DB = 4;
`ifdef SW_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sw_input_port_if #(.n(N)) bus ();

    sw_input_port #(.n(N), .db_cycles(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] sw;
        logic         chg;
        logic         evt;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] hist[$];
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_sw = '0;
    logic         m_chg = 1'b0, m_evt = 1'b0;
    int           vecs = 0, errs = 0, seen_chg = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a bit is accepted when the last DB synchronized samples
    // all disagree with the current output.
    task automatic model_edge(input logic [N-1:0] pin, input logic ack, input logic rst);
        logic [N-1:0] nsw;
        logic         all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_sw = '0; m_chg = 1'b0; m_evt = 1'b0;
            hist.delete();
        end else begin
`ifdef SW_DEBOUNCE_EN
            hist.push_back(m_s2);
            if (hist.size() > DB) void'(hist.pop_front());
            nsw = m_sw;
            if (hist.size() == DB) begin
                for (int i = 0; i < N; i++) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][i] == m_sw[i]) all_diff = 1'b0;
                    if (all_diff) nsw[i] = ~m_sw[i];
                end
            end
`else
            nsw = m_s1;
`endif
            m_chg = (nsw != m_sw);
            m_evt = m_chg | (m_evt & ~ack);
            m_s2  = m_s1;
            m_s1  = pin;
            m_sw  = nsw;
        end
        sb.push_back('{m_sw, m_chg, m_evt});
    endtask

    task automatic step(input logic [N-1:0] pin, input logic ack, input logic rst);
        exp_t e;
        bus.sw_pin = pin;
        bus.sw_ack = ack;
        reset      = rst;
        model_edge(pin, ack, rst);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sw", bus.sw, e.sw);
        chk("sw_changed", N'(bus.sw_changed), N'(e.chg));
        chk("sw_event", N'(bus.sw_event), N'(e.evt));
        if (bus.sw_changed) seen_chg++;
    endtask

    initial begin
        logic [N-1:0] pin;
        int           hold;
        bus.sw_pin = '0;
        bus.sw_ack = 1'b0;

        // All pins high from reset.
        repeat (3) step('1, 1'b0, 1'b1);
        chk("rst_sw", bus.sw, '0);
        chk("rst_evt", N'(bus.sw_event), '0);
        seen_chg = 0;
        repeat (LAT - 1) step('1, 1'b0, 1'b0);
        chk("rst_early", bus.sw, '0);
        step('1, 1'b0, 1'b0);
        chk("rst_latency", bus.sw, 9'h1FF);
        chk("rst_pulse", N'(bus.sw_changed), 9'h001);
        step('1, 1'b0, 1'b0);
        chk("rst_pulse_end", N'(bus.sw_changed), '0);
        chk("rst_pulse_count", N'(seen_chg), 9'h001);

        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
        seen_chg = 0;
`ifdef SW_DEBOUNCE_EN
        // Excursion shorter than the debounce window.
        repeat (3) step(9'h001, 1'b0, 1'b0);
        repeat (LAT + 2) step('0, 1'b0, 1'b0);
        chk("glitch_sw", bus.sw, '0);
        chk("glitch_chg", N'(seen_chg), '0);
`else
        // One-cycle pin pulse passes straight through after two edges.
        step(9'h008, 1'b0, 1'b0);
        chk("pulse_early", bus.sw, '0);
        step('0, 1'b0, 1'b0);
        chk("pulse_rise", bus.sw, 9'h008);
        chk("pulse_rise_chg", N'(bus.sw_changed), 9'h001);
        step('0, 1'b0, 1'b0);
        chk("pulse_fall", bus.sw, '0);
        chk("pulse_fall_chg", N'(bus.sw_changed), 9'h001);
        step('0, 1'b0, 1'b0);
        chk("pulse_quiet", N'(bus.sw_changed), '0);
        chk("pulse_count", N'(seen_chg), 9'h002);
`endif
        step('0, 1'b1, 1'b0);

        // Data byte, sticky event and acknowledge.
        seen_chg = 0;
        repeat (LAT - 1) step(9'h01E, 1'b0, 1'b0);
        chk("data_early", bus.sw, '0);
        step(9'h01E, 1'b0, 1'b0);
        chk("data_sw", bus.sw, 9'h01E);
        chk("data_chg", N'(bus.sw_changed), 9'h001);
        repeat (3) step(9'h01E, 1'b0, 1'b0);
        chk("data_evt_hold", N'(bus.sw_event), 9'h001);
        chk("data_count", N'(seen_chg), 9'h001);
        step(9'h01E, 1'b1, 1'b0);
        chk("data_ack", N'(bus.sw_event), '0);
        step(9'h01E, 1'b1, 1'b0);
        chk("idle_ack", N'(bus.sw_event), '0);

        // Ack coincides with acceptance of the mode bit: set wins.
        repeat (LAT - 1) step(9'h11E, 1'b0, 1'b0);
        step(9'h11E, 1'b1, 1'b0);
        chk("coll_sw", bus.sw, 9'h11E);
        chk("coll_evt", N'(bus.sw_event), 9'h001);
        step(9'h11E, 1'b0, 1'b0);
        chk("coll_evt_hold", N'(bus.sw_event), 9'h001);
        step(9'h11E, 1'b1, 1'b0);
        chk("coll_ack", N'(bus.sw_event), '0);

        // Reset in the middle of a count.
        step('0, 1'b0, 1'b1);
        repeat (4) step(9'h0FD, 1'b0, 1'b0);
        step(9'h0FD, 1'b0, 1'b1);
        chk("mid_rst_sw", bus.sw, '0);
        repeat (LAT - 1) step(9'h0FD, 1'b0, 1'b0);
        chk("mid_rst_early", bus.sw, '0);
        step(9'h0FD, 1'b0, 1'b0);
        chk("mid_rst_sw_final", bus.sw, 9'h0FD);

        // Random pins with varied hold times, acks and occasional resets.
        hold = 0;
        pin  = '0;
        for (int k = 0; k < 400; k++) begin
            if (hold == 0) begin
                pin  = N'($urandom);
                hold = $urandom_range(1, 2 * DB + 2);
            end
            hold--;
            step(pin, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
